// File: rtl/serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_frame_tx : start / LSB-first data / optional even parity / stop     |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [BAUD_W-1:0]  baud;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               parity;
    logic               bit_end;
    logic [DATA_W-1:0]  shifted;

    assign bit_end = (baud == BAUD_LAST);
    assign shifted = shreg >> 1;

    // tx_line is registered for the state being entered, so each bit begins
    // exactly on the rising edge that starts its first cycle.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            tx_ready   <= 1'b0;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud    <= '0;
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        parity   <= ^tx_data;
                        bit_idx  <= '0;
                        state    <= START;
                        tx_line  <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_ready <= 1'b0;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_line <= shreg[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                state   <= PARITY;
                                tx_line <= parity;
                            end else begin
                                state   <= STOP;
                                tx_line <= 1'b1;
                            end
                        end else begin
                            shreg   <= shifted;
                            tx_line <= shifted[0];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud    <= '0;
                        state   <= STOP;
                        tx_line <= 1'b1;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud     <= '0;
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        tx_ready <= 1'b1;
                        tx_line  <= 1'b1;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                        // Raise the pulse one edge early so it covers the final STOP cycle.
                        if (baud == BAUD_PRE) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud     <= '0;
                    tx_ready <= 1'b0;
                    tx_busy  <= 1'b0;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_frame_tx : bench for serial_frame_tx, parity and no-parity forms |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_serial_frame_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       async_rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, line_a, busy_a, done_a;
    logic       ready_b, line_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) dut_a (
        .clk(clk), .async_rst(async_rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_line(line_a), .tx_busy(busy_a), .frame_done(done_a)
    );

    serial_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) dut_b (
        .clk(clk), .async_rst(async_rst), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .tx_line(line_b), .tx_busy(busy_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame is a list of bit values, each lasting CPB cycles.
    // sel=0 -> parity instance, sel=1 -> no-parity instance.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit keep,
                              input int glitch_at, input logic [7:0] gdata,
                              output int acc_cyc);
        logic bits [0:10];
        int   nbits, len, k;
        nbits = sel ? 10 : 11;
        len   = nbits * CPB;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (!sel) bits[9] = ($countones(d) % 2) == 1;
        bits[nbits-1] = 1'b1;

        if (sel) begin data_b = d; valid_b = 1'b1; end
        else     begin data_a = d; valid_a = 1'b1; end

        k = 0;
        while (!(sel ? ready_b : ready_a) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            chk("ready_wait_timeout", 32'd0, 32'd1);
            valid_a = 1'b0;
            valid_b = 1'b0;
            acc_cyc = -1;
            return;
        end

        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) begin
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
        end

        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == glitch_at) begin
                if (sel) data_b = gdata; else data_a = gdata;
            end
            chk("line",  sel ? line_b  : line_a,  bits[(c-1)/CPB]);
            chk("busy",  sel ? busy_b  : busy_a,  1'b1);
            chk("ready", sel ? ready_b : ready_a, 1'b0);
            chk("done",  sel ? done_b  : done_a,  c == len);
        end

        @(negedge clk);
        chk("idle_ready", sel ? ready_b : ready_a, 1'b1);
        chk("idle_busy",  sel ? busy_b  : busy_a,  1'b0);
        chk("idle_line",  sel ? line_b  : line_a,  1'b1);
        chk("idle_done",  sel ? done_b  : done_a,  1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2;
        logic [7:0] rd;
        bit sel;

        async_rst = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a  = 8'h00; data_b = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_line_a",  line_a,  1'b1);
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_busy_a",  busy_a,  1'b0);
        chk("rst_done_a",  done_a,  1'b0);
        chk("rst_ready_b", ready_b, 1'b0);
        chk("rst_line_b",  line_b,  1'b1);

        async_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rel_a", ready_a, 1'b1);
        chk("ready_after_rel_b", ready_b, 1'b1);

        send_frame(1'b0, 8'hA5, 1'b0, -1, 8'h00, a1);
        send_frame(1'b0, 8'h07, 1'b0, -1, 8'h00, a1);
        send_frame(1'b1, 8'hFF, 1'b0, -1, 8'h00, a1);

        // Held tx_valid: second frame accepted after the single idle cycle.
        send_frame(1'b0, 8'h3C, 1'b1, -1, 8'h00, a1);
        send_frame(1'b0, 8'hC3, 1'b0, -1, 8'h00, a2);
        chk("b2b_gap_a", a2 - a1, 32'd45);
        send_frame(1'b1, 8'h5A, 1'b1, -1, 8'h00, a1);
        send_frame(1'b1, 8'h81, 1'b0, -1, 8'h00, a2);
        chk("b2b_gap_b", a2 - a1, 32'd41);

        send_frame(1'b0, 8'h55, 1'b0, 8, 8'hAA, a1);

        for (int n = 0; n < 10; n++) begin
            sel = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(sel, rd, 1'b0, int'($urandom_range(0, 40)), 8'($urandom), a1);
        end

        // Reset during data bit 3 of a frame on the parity instance.
        data_a = 8'hC6; valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        repeat (18) @(negedge clk);
        chk("mid_bit3_line", line_a, 1'b0);
        chk("mid_busy", busy_a, 1'b1);
        #2;
        async_rst = 1'b0;
        #1;
        chk("async_line", line_a, 1'b1);
        chk("async_busy", busy_a, 1'b0);
        chk("async_ready", ready_a, 1'b0);
        chk("async_done", done_a, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done_a, 1'b0);
            chk("rst_hold_line", line_a, 1'b1);
        end
        async_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_ready", ready_a, 1'b1);
            chk("post_rst_busy",  busy_a,  1'b0);
            chk("post_rst_line",  line_a,  1'b1);
            chk("post_rst_done",  done_a,  1'b0);
        end
        send_frame(1'b0, 8'h96, 1'b0, -1, 8'h00, a1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (legal >= 2).
REQ-002: Parameter DATA_W, default 8, payload bits per frame (legal 1..16).
REQ-003: Parameter PARITY_EN, default 1, 1 = even parity bit inserted after data, 0 = no parity bit.
REQ-004: clk  input  1  block clock; all state updates on rising edge.
REQ-005: async_rst  input  1  reset, asynchronous, active-low.
REQ-006: tx_data  input  DATA_W  payload, sampled only at acceptance.
REQ-007: tx_valid  input  1  payload request.
REQ-008: tx_ready  output  1  block can accept a payload this cycle.
REQ-009: tx_line  output  1  serial line, idle high.
REQ-010: tx_busy  output  1  frame in progress.
REQ-011: frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-012: All outputs registered; tx_line launches on rising edge so that downstream falling-edge capture flops sample mid-cycle.
REQ-013: FSM states IDLE, START, DATA, PARITY, STOP; encoding free.
REQ-014: tx_ready = 1 only in IDLE; acceptance = tx_valid && tx_ready on a rising edge.
REQ-015: At acceptance, tx_data latched into shift register, parity = XOR of tx_data, FSM -> START.
REQ-016: tx_data/tx_valid changes after acceptance have no effect on the current frame.
REQ-017: START drives tx_line = 0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-018: DATA sends DATA_W bits LSB first, each held exactly CLKS_PER_BIT cycles; bit index counter width ceil(log2(DATA_W+1)).
REQ-019: After last data bit: -> PARITY if PARITY_EN = 1, else -> STOP.
REQ-020: PARITY drives the even-parity bit (total ones in data+parity is even) for CLKS_PER_BIT cycles, then -> STOP.
REQ-021: STOP drives tx_line = 1 for CLKS_PER_BIT cycles, then -> IDLE.
REQ-022: frame_done = 1 exactly during the last cycle of STOP; 0 otherwise.
REQ-023: tx_busy = 1 in every state except IDLE.
REQ-024: Frame length = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, first START cycle is the cycle after acceptance.
REQ-025: Minimum one IDLE cycle between frames; back-to-back period = frame length + 1 cycles.
REQ-026: Baud counter counts 0..CLKS_PER_BIT-1, clears on every bit/state transition; no wrap drift across bits.
REQ-027: tx_valid held high during a frame is not a new request; next acceptance only in IDLE.
REQ-028: tx_line = 1 in IDLE.

Reset
REQ-029: async_rst = 0 forces immediately, without clk: state IDLE, tx_line = 1, tx_ready = 0, tx_busy = 0, frame_done = 0, counters and shift register = 0.
REQ-030: tx_ready rises on the first rising edge after async_rst deasserts.
REQ-031: Reset mid-frame aborts the frame; no frame_done pulse; partial frame not resumed.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-032: PARITY_EN=1, send 0xA5 -> tx_line bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each 4 cycles, 44 cycles total, frame_done on cycle 44.
REQ-033: PARITY_EN=1, send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit = 1.
REQ-034: PARITY_EN=0, send 0xFF -> 40-cycle frame, no parity bit, stop immediately after bit 7.
REQ-035: tx_valid held high with 0x3C then 0xC3 -> two frames 45 cycles apart, tx_ready high exactly one cycle between them.
REQ-036: Change tx_data from 0x55 to 0xAA mid-frame -> line carries 0x55 unchanged.
REQ-037: async_rst low during DATA bit 3 -> tx_line = 1, tx_busy = 0 without a clk edge, no frame_done, new frame after release starts cleanly.
